// File: rtl/collision_detector.sv
// Per-frame player/obstacle collision detector with per-lane rising-edge pulses
// and a saturating hit counter. Define COLLISION_HCHECK_EN to also require horizontal overlap.
module collision_detector #(
  parameter int POS_WIDTH    = 12,
  parameter int POS_MISMATCH = 50,
  parameter int OBST_LANE    = 1,
  parameter int COUNT_WIDTH  = 32,
  parameter int H_MISMATCH   = 40
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rst_count,
  input  logic                        ignore_obstacle,
  input  logic signed [POS_WIDTH-1:0] player_hoffset,
  input  logic signed [POS_WIDTH-1:0] player_voffset,
  input  logic        [1:0]           player_lane,
  input  logic signed [POS_WIDTH-1:0] obst_hoffset,
  input  logic signed [POS_WIDTH-1:0] obst_voffset,
  input  logic        [1:0]           obst_lane [OBST_LANE],
  output logic        [COUNT_WIDTH-1:0] count,
  output logic        [OBST_LANE-1:0]   has_collision
);

  localparam logic [POS_WIDTH:0]   V_WIN     = (POS_WIDTH+1)'(POS_MISMATCH);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};

  // Widen by one bit before subtracting so opposite-sign extremes cannot wrap.
  function automatic logic [POS_WIDTH:0] abs_diff(
    input logic signed [POS_WIDTH-1:0] a,
    input logic signed [POS_WIDTH-1:0] b
  );
    logic signed [POS_WIDTH:0] d;
    d = $signed({a[POS_WIDTH-1], a}) - $signed({b[POS_WIDTH-1], b});
    abs_diff = d[POS_WIDTH] ? (-d) : d;
  endfunction

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(
    input logic [COUNT_WIDTH-1:0] c,
    input logic                   inc
  );
    sat_inc = (inc && (c != COUNT_MAX)) ? c + 1'b1 : c;
  endfunction

  logic                   vmatch;
  logic                   hmatch;
  logic                   lane_valid;
  logic [OBST_LANE-1:0]   hit_raw;
  logic [OBST_LANE-1:0]   new_hit;

  logic [OBST_LANE-1:0]   prev_hit_d, prev_hit_q;
  logic [OBST_LANE-1:0]   has_collision_d, has_collision_q;
  logic [COUNT_WIDTH-1:0] count_d, count_q;

  assign vmatch     = abs_diff(obst_voffset, player_voffset) < V_WIN;
  assign lane_valid = (player_lane != 2'd3);

`ifdef COLLISION_HCHECK_EN
  localparam logic [POS_WIDTH:0] H_WIN = (POS_WIDTH+1)'(H_MISMATCH);
  assign hmatch = abs_diff(obst_hoffset, player_hoffset) < H_WIN;
`else
  logic unused_hoffsets;
  assign unused_hoffsets = ^{player_hoffset, obst_hoffset};
  assign hmatch          = 1'b1;
`endif

  // Stage 0: raw overlap, rising-edge detect against last frame, next-state
  always_comb begin
    hit_raw = '0;
    for (int i = 0; i < OBST_LANE; i++) begin
      hit_raw[i] = ~ignore_obstacle & (obst_lane[i] == player_lane) &
                   lane_valid & vmatch & hmatch;
    end
    new_hit         = hit_raw & ~prev_hit_q;
    prev_hit_d      = hit_raw;
    has_collision_d = new_hit;
    count_d         = sat_inc(count_q, |new_hit);
    // prev_hit keeps tracking through a clear so an ongoing overlap is consumed.
    if (rst_count) begin
      has_collision_d = '0;
      count_d         = '0;
    end
  end

  // Stage 1: registered outputs and edge-detect history
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_hit_q      <= '0;
      has_collision_q <= '0;
      count_q         <= '0;
    end else begin
      prev_hit_q      <= prev_hit_d;
      has_collision_q <= has_collision_d;
      count_q         <= count_d;
    end
  end

  assign has_collision = has_collision_q;
  assign count         = count_q;

endmodule

// File: tb/tb_collision_detector.sv
// Scoreboard bench for collision_detector: a wide-counter two-lane instance and a
// two-bit-counter one-lane instance share stimulus and are checked against a frame model.
module tb_collision_detector;

  localparam int PM = 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, rst_count, ignore_obstacle;
  logic        [1:0]  player_lane;
  logic signed [11:0] player_hoffset, player_voffset, obst_hoffset, obst_voffset;
  logic        [1:0]  obst_lane_a [2];
  logic        [1:0]  obst_lane_s [1];
  logic        [31:0] count_a;
  logic        [1:0]  hc_a;
  logic        [1:0]  count_s;
  logic        [0:0]  hc_s;

  collision_detector #(.POS_WIDTH(12), .POS_MISMATCH(PM), .OBST_LANE(2),
                       .COUNT_WIDTH(32), .H_MISMATCH(40)) dut_a (
    .clk(clk), .rst(rst), .rst_count(rst_count), .ignore_obstacle(ignore_obstacle),
    .player_hoffset(player_hoffset), .player_voffset(player_voffset),
    .player_lane(player_lane), .obst_hoffset(obst_hoffset),
    .obst_voffset(obst_voffset), .obst_lane(obst_lane_a),
    .count(count_a), .has_collision(hc_a));

  collision_detector #(.POS_WIDTH(12), .POS_MISMATCH(PM), .OBST_LANE(1),
                       .COUNT_WIDTH(2), .H_MISMATCH(40)) dut_s (
    .clk(clk), .rst(rst), .rst_count(rst_count), .ignore_obstacle(ignore_obstacle),
    .player_hoffset(player_hoffset), .player_voffset(player_voffset),
    .player_lane(player_lane), .obst_hoffset(obst_hoffset),
    .obst_voffset(obst_voffset), .obst_lane(obst_lane_s),
    .count(count_s), .has_collision(hc_s));

  typedef struct {
    int         phase;
    logic [1:0] hc_a;
    longint     cnt_a;
    logic       hc_s;
    longint     cnt_s;
  } exp_t;

  exp_t   sb[$];
  int     tests = 0;
  int     fails = 0;
  int     phase = 0;
  bit     ref_prev_a [2];
  bit     ref_prev_s;
  longint ref_cnt_a;
  longint ref_cnt_s;

  function automatic int absdiff(input int a, input int b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  // Frame model: overlap is plain integer distance; a pulse is "overlap now, not last frame".
  task automatic drive(input bit r, input bit rc, input bit ign,
                       input int pl, input int pv, input int ov,
                       input int l0, input int l1);
    exp_t e;
    bit   hit_a [2];
    bit   hit_s, rise_a0, rise_a1, rise_s;
    int   vd;
    @(negedge clk);
    rst             = r;
    rst_count       = rc;
    ignore_obstacle = ign;
    player_lane     = 2'(pl);
    player_voffset  = 12'(pv);
    obst_voffset    = 12'(ov);
    obst_lane_a[0]  = 2'(l0);
    obst_lane_a[1]  = 2'(l1);
    obst_lane_s[0]  = 2'(l0);
    player_hoffset  = 12'($urandom);
    obst_hoffset    = 12'($urandom);

    vd        = absdiff(int'(player_voffset), int'(obst_voffset));
    hit_a[0]  = !ign && (l0 == pl) && (pl != 3) && (vd < PM);
    hit_a[1]  = !ign && (l1 == pl) && (pl != 3) && (vd < PM);
    hit_s     = hit_a[0];
    rise_a0   = hit_a[0] && !ref_prev_a[0];
    rise_a1   = hit_a[1] && !ref_prev_a[1];
    rise_s    = hit_s && !ref_prev_s;

    e.phase = phase;
    if (r) begin
      ref_prev_a[0] = 0; ref_prev_a[1] = 0; ref_prev_s = 0;
      ref_cnt_a = 0; ref_cnt_s = 0;
      e.hc_a = 2'b00; e.hc_s = 1'b0;
    end else begin
      ref_prev_a[0] = hit_a[0]; ref_prev_a[1] = hit_a[1]; ref_prev_s = hit_s;
      if (rc) begin
        ref_cnt_a = 0; ref_cnt_s = 0;
        e.hc_a = 2'b00; e.hc_s = 1'b0;
      end else begin
        e.hc_a = {rise_a1, rise_a0};
        e.hc_s = rise_s;
        if ((rise_a0 || rise_a1) && ref_cnt_a < 64'd4294967295) ref_cnt_a++;
        if (rise_s && ref_cnt_s < 3) ref_cnt_s++;
      end
    end
    e.cnt_a = ref_cnt_a;
    e.cnt_s = ref_cnt_s;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input int ph, input logic [63:0] got,
                     input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s phase=%0d got=%0d want=%0d", name, ph, got, want);
    end
  endtask

  // Monitor: every frame the DUTs present fresh outputs one edge after sampling.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("has_collision_a", e.phase, {62'b0, hc_a},    {62'b0, e.hc_a});
      chk("count_a",         e.phase, {32'b0, count_a}, 64'(e.cnt_a));
      chk("has_collision_s", e.phase, {63'b0, hc_s},    {63'b0, e.hc_s});
      chk("count_s",         e.phase, {62'b0, count_s}, 64'(e.cnt_s));
    end
  end

  task automatic sweep(input int pl);
    for (int v = -140; v <= 220; v += 32) drive(0, 0, 0, pl, 50, v, 1, 3);
    drive(0, 0, 0, pl, 50, 900, 1, 3);
  endtask

  task automatic hit_once(input int n);
    for (int k = 0; k < n; k++) begin
      drive(0, 0, 0, 1, 10, 20, 1, 0);
      drive(0, 0, 0, 1, 10, 20, 1, 0);
      drive(0, 0, 0, 1, 10, 600, 1, 0);
    end
  endtask

  initial begin
    int budget;
    phase = 1;
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 1, 0, 0, 1, 1);

    phase = 2; sweep(1);
    drive(0, 1, 0, 1, 50, 900, 1, 3);
    phase = 3; sweep(0);
    phase = 4; sweep(3);

    phase = 5;
    drive(0, 0, 1, 2, 50, -140, 1, 2);
    drive(0, 0, 1, 2, 50, -44, 1, 2);
    drive(0, 0, 1, 2, 50, -12, 1, 2);
    drive(0, 0, 0, 2, 50, 20, 1, 2);
    drive(0, 0, 0, 2, 50, 52, 1, 2);
    drive(0, 0, 0, 2, 50, 900, 1, 2);
    drive(0, 0, 0, 0, 50, 20, 1, 2);
    drive(0, 0, 0, 1, 50, 20, 1, 2);
    drive(0, 0, 0, 2, 50, 20, 1, 2);

    phase = 6;
    drive(0, 1, 0, 1, 0, 900, 1, 1);
    drive(0, 0, 0, 1, 0, 100, 1, 1);
    drive(0, 0, 0, 1, 0, 900, 1, 1);
    drive(0, 0, 0, 1, 0, 99, 1, 1);
    drive(0, 0, 0, 1, 0, 900, 1, 1);
    drive(0, 0, 0, 1, 0, -100, 1, 1);
    drive(0, 0, 0, 1, 0, 900, 1, 1);
    drive(0, 0, 0, 1, 0, -99, 1, 1);
    drive(0, 0, 0, 1, 0, 900, 1, 1);

    phase = 7;
    drive(0, 1, 0, 1, 10, 600, 1, 0);
    hit_once(3);
    drive(0, 0, 0, 1, 10, 20, 1, 0);
    drive(0, 1, 0, 1, 10, 20, 1, 0);
    for (int k = 0; k < 3; k++) drive(0, 0, 0, 1, 10, 20, 1, 0);
    drive(0, 1, 0, 1, 10, 20, 1, 0);
    drive(0, 0, 0, 1, 10, 20, 1, 0);
    drive(1, 0, 0, 1, 10, 20, 1, 0);
    drive(0, 0, 0, 1, 10, 20, 1, 0);
    drive(0, 0, 0, 1, 10, 600, 1, 0);

    phase = 8;
    drive(0, 1, 0, 1, 10, 600, 1, 0);
    hit_once(5);

    phase = 9;
    drive(0, 0, 0, 1, 2047, -2048, 1, 1);
    drive(0, 0, 0, 1, -2048, 2047, 1, 1);
    drive(0, 0, 0, 1, 2047, 1990, 1, 1);
    drive(0, 0, 0, 1, -2048, -1960, 1, 1);
    drive(0, 0, 0, 1, -2048, 900, 1, 1);

    phase = 10;
    for (int k = 0; k < 400; k++) begin
      drive(($urandom % 64) == 0, ($urandom % 24) == 0, ($urandom % 4) == 0,
            int'($urandom % 4), int'($urandom_range(240)) - 120,
            int'($urandom_range(300)) - 150, int'($urandom % 4), int'($urandom % 4));
    end
    drive(0, 0, 0, 3, 0, 0, 0, 0);

    budget = 0;
    while (sb.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    #2;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain pending=%0d want=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
